decode_stage: RTL

Instruction decode stage sitting directly downstream of the fetch stage (PC register + instruction memory). Captures each fetched PC/instruction pair into a fetch/decode pipeline register with stall-hold and flush-bubble control. Presents the registered instruction's RV32I fields, a sign-extended immediate and an illegal-opcode flag to the execute/register-file logic. Keeps a retired-into-decode instruction counter for debug.

---
 rtl/rv32_pkg.sv | 28 ++
 rtl/imm_gen.sv | 34 +++
 rtl/decode_stage.sv | 96 +++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I opcode constants, NOP encoding and reset PC shared by the pipeline
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate extraction and sign extension
//
// Ports:
//   insn_i  32  instruction word
//   imm_o   32  sign-extended immediate for the instruction's format (0 for R-type/fence/unknown)
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] insn_i,
    output logic [31:0] imm_o
);

    logic [6:0] opcode;
    assign opcode = insn_i[6:0];

    always_comb begin
        imm_o = 32'h0000_0000;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                imm_o = {{20{insn_i[31]}}, insn_i[31:20]};
            OP_STORE:
                imm_o = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            OP_BRANCH:
                imm_o = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_o = {insn_i[31:12], 12'b0};
            OP_JAL:
                imm_o = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
            default:
                imm_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - fetch/decode pipeline register with stall/flush, RV32I field decode and capture counter
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   f_pc, f_insn, f_valid    fetched PC/instruction and its valid flag
//   stall, flush             hold register / replace with bubble (flush wins)
//   d_valid, d_pc, d_insn    registered instruction
//   d_opcode..d_funct7       combinational field slices of d_insn
//   d_imm                    sign-extended immediate for d_opcode's format
//   d_illegal                d_valid with an opcode outside RV32I
//   insn_count               number of valid instructions captured (wraps)
module decode_stage
    import rv32_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] f_pc,
    input  logic [31:0] f_insn,
    input  logic        f_valid,
    input  logic        stall,
    input  logic        flush,
    output logic        d_valid,
    output logic [31:0] d_pc,
    output logic [31:0] d_insn,
    output logic [6:0]  d_opcode,
    output logic [4:0]  d_rd,
    output logic [4:0]  d_rs1,
    output logic [4:0]  d_rs2,
    output logic [2:0]  d_funct3,
    output logic [6:0]  d_funct7,
    output logic [31:0] d_imm,
    output logic        d_illegal,
    output logic [31:0] insn_count
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] insn_count_q, insn_count_d;

    // Priority: flush > stall > capture. Reset is applied in the register process.
    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        insn_d       = insn_q;
        insn_count_d = insn_count_q;
        if (flush) begin
            // Bubble keeps the fetch PC so debug sees where the squashed slot was.
            valid_d = 1'b0;
            pc_d    = f_pc;
            insn_d  = NOP;
        end else if (!stall) begin
            valid_d = f_valid;
            pc_d    = f_pc;
            // An invalid fetch slot becomes a NOP so field decode never sees garbage.
            insn_d  = f_valid ? f_insn : NOP;
            if (f_valid) begin
                insn_count_d = insn_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= 1'b0;
            pc_q         <= RESET_PC;
            insn_q       <= NOP;
            insn_count_q <= 32'h0000_0000;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            insn_q       <= insn_d;
            insn_count_q <= insn_count_d;
        end
    end

    assign d_valid    = valid_q;
    assign d_pc       = pc_q;
    assign d_insn     = insn_q;
    assign insn_count = insn_count_q;

    assign d_opcode = insn_q[6:0];
    assign d_rd     = insn_q[11:7];
    assign d_funct3 = insn_q[14:12];
    assign d_rs1    = insn_q[19:15];
    assign d_rs2    = insn_q[24:20];
    assign d_funct7 = insn_q[31:25];

    assign d_illegal = valid_q && !is_legal_opcode(insn_q[6:0]);

    imm_gen u_imm_gen (
        .insn_i (insn_q),
        .imm_o  (d_imm)
    );

endmodule
